// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential-multiplier sharing arbiter.
// Holds the arbiter state encoding, default sizing and the pointer-width helper.
package seq_mult_pkg;

  localparam int DW          = 8;
  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DELIVER
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int PTR_W(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_priority_pick.sv
// Rotating priority encoder: searches i_req upward from i_rrPtr with wrap and
// returns the first set requester as both a one-hot vector and an index.
module rr_priority_pick
  #(parameter int N  = 4,
    parameter int PW = 2)
  (input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_rrPtr,
   output logic [N-1:0]  o_winner,
   output logic [PW-1:0] o_winIdx,
   output logic          o_any);

  always_comb begin : pick
    int j;
    j        = 0;
    o_winner = '0;
    o_winIdx = '0;
    o_any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_rrPtr) + k;
      if (j >= N) j = j - N;
      if (!o_any && i_req[j]) begin
        o_any       = 1'b1;
        o_winner[j] = 1'b1;
        o_winIdx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one signed sequential multiplier among N_REQ
// requesters, with a WAIT watchdog that aborts a transaction lacking ready.
module mult_share_arbiter
  import seq_mult_pkg::*;
  #(parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF)
  (input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] op_a,
   input  logic [N_REQ*DW-1:0] op_b,
   output logic [N_REQ-1:0]    grant,
   output logic [N_REQ-1:0]    done,
   output logic                err,
   output logic [2*DW-1:0]     result,
   output logic                busy,
   output logic                mult_start,
   output logic [DW-1:0]       mult_a,
   output logic [DW-1:0]       mult_b,
   input  logic                mult_ready,
   input  logic [2*DW-1:0]     mult_product);

  localparam int PW  = PTR_W(N_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e        r_state;
  logic [PW-1:0]     r_rrPtr;
  logic [PW-1:0]     r_winIdx;
  logic              r_armed;
  logic [WDW-1:0]    r_wdog;
  logic [N_REQ-1:0]  r_grant;
  logic [N_REQ-1:0]  r_done;
  logic              r_err;
  logic [2*DW-1:0]   r_result;
  logic              r_busy;
  logic              r_multStart;
  logic [DW-1:0]     r_multA;
  logic [DW-1:0]     r_multB;

  logic [N_REQ-1:0]  w_winner;
  logic [PW-1:0]     w_winIdx;
  logic              w_any;
  logic              w_readyHit;
  logic              w_timeout;

  rr_priority_pick #(.N(N_REQ), .PW(PW)) u_pick
    (.i_req   (req),
     .i_rrPtr (r_rrPtr),
     .o_winner(w_winner),
     .o_winIdx(w_winIdx),
     .o_any   (w_any));

  // Ready only counts once it has been seen low, so a level left over from the
  // previous operation cannot complete this one; ready beats a same-cycle timeout.
  assign w_readyHit = mult_ready && r_armed;
  assign w_timeout  = (r_wdog == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rrPtr     <= '0;
      r_winIdx    <= '0;
      r_armed     <= 1'b0;
      r_wdog      <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_multStart <= 1'b0;
      r_multA     <= '0;
      r_multB     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant     <= w_winner;
            r_winIdx    <= w_winIdx;
            r_multA     <= op_a[int'(w_winIdx)*DW +: DW];
            r_multB     <= op_b[int'(w_winIdx)*DW +: DW];
            r_multStart <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_multStart <= 1'b0;
          r_armed     <= 1'b0;
          r_wdog      <= '0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_readyHit) begin
            r_result <= mult_product;
            r_done   <= r_grant;
            r_err    <= 1'b0;
            r_state  <= ST_DELIVER;
          end else if (w_timeout) begin
            r_result <= '0;
            r_done   <= r_grant;
            r_err    <= 1'b1;
            r_state  <= ST_DELIVER;
          end else begin
            r_wdog <= r_wdog + WDW'(1);
            if (!mult_ready) r_armed <= 1'b1;
          end
        end
        ST_DELIVER: begin
          r_done  <= '0;
          r_err   <= 1'b0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_rrPtr <= (r_winIdx == PW'(N_REQ - 1)) ? '0 : r_winIdx + PW'(1);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign err        = r_err;
  assign result     = r_result;
  assign busy       = r_busy;
  assign mult_start = r_multStart;
  assign mult_a     = r_multA;
  assign mult_b     = r_multB;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: behavioural sequential multiplier,
// a scoreboard of expected done/result/err, a vector table and corner sequences.
module tb_mult_share_arbiter;
  import seq_mult_pkg::*;

  localparam int N  = 4;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   opA = '0;
  logic [N*DW-1:0]   opB = '0;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              err;
  logic [2*DW-1:0]   result;
  logic              busy;
  logic              multStart;
  logic [DW-1:0]     multA;
  logic [DW-1:0]     multB;
  logic              mReady;
  logic [2*DW-1:0]   mProduct;

  logic [DW-1:0]     mA;
  logic [DW-1:0]     mB;
  logic              mBusy;
  int                mCnt;
  int                modelLat    = 10;
  int                staleCycles = 0;
  bit                neverReady  = 1'b0;

  int                nChecks = 0;
  int                nFails  = 0;
  int                cyc     = 0;

  typedef struct {
    logic [N-1:0]    done;
    logic [2*DW-1:0] res;
    logic            err;
  } exp_t;
  exp_t sbQ[$];
  exp_t monExp;

  typedef struct {
    int              idx;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] res;
  } vec_t;
  vec_t vecs[7];

  mult_share_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut
    (.clk(clk), .rst(rst), .req(req), .op_a(opA), .op_b(opB),
     .grant(grant), .done(done), .err(err), .result(result), .busy(busy),
     .mult_start(multStart), .mult_a(multA), .mult_b(multB),
     .mult_ready(mReady), .mult_product(mProduct));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*DW-1:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] sa, sb;
    sa = {{DW{a[DW-1]}}, a};
    sb = {{DW{b[DW-1]}}, b};
    return sa * sb;
  endfunction

  // Sequential multiplier: ready is a level that falls after start (or after
  // staleCycles cycles) and rises modelLat cycles after start with the product.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mReady   <= 1'b0;
      mProduct <= '0;
      mBusy    <= 1'b0;
      mCnt     <= 0;
      mA       <= '0;
      mB       <= '0;
    end else if (multStart) begin
      mA    <= multA;
      mB    <= multB;
      mBusy <= 1'b1;
      mCnt  <= 1;
      if (staleCycles == 0) mReady <= 1'b0;
    end else if (mBusy) begin
      mCnt <= mCnt + 1;
      if (mCnt == staleCycles) mReady <= 1'b0;
      if (!neverReady && mCnt == modelLat) begin
        mReady   <= 1'b1;
        mProduct <= smul(mA, mB);
        mBusy    <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input int idx, input logic [2*DW-1:0] res, input logic e);
    exp_t x;
    x.done      = '0;
    x.done[idx] = 1'b1;
    x.res       = res;
    x.err       = e;
    sbQ.push_back(x);
  endtask

  // Every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done != '0) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'(done), 32'h0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("doneOneHot", 32'(done), 32'(monExp.done));
        checkOutput("result", 32'(result), 32'(monExp.res));
        checkOutput("err", 32'(err), 32'(monExp.err));
      end
    end
  end

  task automatic waitDone(input int maxCyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge clk);
      if (done != '0) seen = 1'b1;
    end
    if (!seen) checkOutput("doneTimeout", 32'h0, 32'h1);
  endtask

  task automatic setSlice(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
    opA[idx*DW +: DW] = a;
    opB[idx*DW +: DW] = b;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One isolated request: launch timing, scrambled operands after the grant,
  // done via the scoreboard, and busy low in the cycle after done.
  task automatic applyStimulus(input int idx, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [2*DW-1:0] res);
    logic [N-1:0] oh;
    oh       = '0;
    oh[idx]  = 1'b1;
    opA      = $urandom;
    opB      = $urandom;
    setSlice(idx, a, b);
    req      = oh;
    pushExp(idx, res, 1'b0);
    @(negedge clk);
    checkOutput("grantAtT1", 32'(grant), 32'(oh));
    checkOutput("startAtT1", 32'(multStart), 32'h1);
    checkOutput("busyInLaunch", 32'(busy), 32'h1);
    opA = $urandom;
    opB = $urandom;
    @(negedge clk);
    checkOutput("startPulseWidth", 32'(multStart), 32'h0);
    waitDone(200);
    req = '0;
    @(negedge clk);
    checkOutput("busyAfterDone", 32'(busy), 32'h0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [DW-1:0] ca[4];
    logic [DW-1:0] cb[4];
    int startCyc;
    int prevCyc;

    vecs[0] = '{0, 8'h05, 8'hFD, 16'hFFF1};
    vecs[1] = '{1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[2] = '{2, 8'h80, 8'h80, 16'h4000};
    vecs[3] = '{3, 8'h80, 8'h7F, 16'hC080};
    vecs[4] = '{1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[5] = '{2, 8'h00, 8'h5A, 16'h0000};
    vecs[6] = '{3, 8'h0C, 8'hF6, 16'hFF88};
    ca = '{8'h03, 8'hF0, 8'h7E, 8'h81};
    cb = '{8'h09, 8'h02, 8'hFF, 8'h81};

    // Reset values
    @(negedge clk);
    checkOutput("rstGrant", 32'(grant), 32'h0);
    checkOutput("rstDone", 32'(done), 32'h0);
    checkOutput("rstErr", 32'(err), 32'h0);
    checkOutput("rstResult", 32'(result), 32'h0);
    checkOutput("rstBusy", 32'(busy), 32'h0);
    checkOutput("rstStart", 32'(multStart), 32'h0);
    checkOutput("rstMultA", 32'(multA), 32'h0);
    checkOutput("rstMultB", 32'(multB), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single-request vector table");
    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].res);

    $display("[TB] contention with all requests held");
    resetDut();
    for (int i = 0; i < N; i++) setSlice(i, ca[i], cb[i]);
    for (int k = 0; k < 5; k++) pushExp(k % N, smul(ca[k % N], cb[k % N]), 1'b0);
    req = '1;
    prevCyc = 0;
    for (int k = 0; k < 5; k++) begin
      waitDone(200);
      if (k > 0) checkOutput("doneSpacing", 32'(cyc - prevCyc >= modelLat + 4), 32'h1);
      prevCyc = cyc;
    end
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] round-robin pointer wrap");
    resetDut();
    applyStimulus(1, 8'h21, 8'h03, 16'h0063);
    setSlice(0, 8'hFE, 8'h40);
    setSlice(1, 8'h11, 8'h11);
    pushExp(0, 16'hFF80, 1'b0);
    pushExp(1, 16'h0121, 1'b0);
    req = 4'b0011;
    waitDone(200);
    req = 4'b0010;
    waitDone(200);
    req = '0;
    @(negedge clk);

    $display("[TB] stale ready held through launch");
    staleCycles = 3;
    applyStimulus(2, 8'h13, 8'h0B, 16'h00D1);
    staleCycles = 0;

    $display("[TB] watchdog timeout");
    neverReady = 1'b1;
    opA = $urandom;
    opB = $urandom;
    setSlice(3, 8'h22, 8'h22);
    pushExp(3, 16'h0000, 1'b1);
    req = 4'b1000;
    @(negedge clk);
    checkOutput("timeoutStart", 32'(multStart), 32'h1);
    startCyc = cyc;
    waitDone(150);
    checkOutput("timeoutCycles", 32'(cyc - startCyc), 32'(TO + 1));
    req = '0;
    neverReady = 1'b0;
    @(negedge clk);
    applyStimulus(0, 8'h0C, 8'hF6, 16'hFF88);

    $display("[TB] reset during WAIT");
    applyStimulus(1, 8'h09, 8'h09, 16'h0051);
    setSlice(2, 8'h44, 8'h02);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstGrant", 32'(grant), 32'h0);
    checkOutput("asyncRstDone", 32'(done), 32'h0);
    checkOutput("asyncRstErr", 32'(err), 32'h0);
    checkOutput("asyncRstResult", 32'(result), 32'h0);
    checkOutput("asyncRstBusy", 32'(busy), 32'h0);
    checkOutput("asyncRstStart", 32'(multStart), 32'h0);
    checkOutput("asyncRstMultA", 32'(multA), 32'h0);
    checkOutput("asyncRstMultB", 32'(multB), 32'h0);
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    setSlice(0, 8'h06, 8'h07);
    setSlice(2, 8'hF9, 8'h03);
    pushExp(0, 16'h002A, 1'b0);
    pushExp(2, 16'hFFEB, 1'b0);
    req = 4'b0101;
    waitDone(200);
    req = 4'b0100;
    waitDone(200);
    req = '0;
    repeat (3) @(negedge clk);

    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
